// File: rtl/ysyx_25060170_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_25060170_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} ifu_state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INCR  = 32'd4;

  // One slot presented to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } ifu_slot_t;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_25060170_reg.sv
// Generic write-enabled register with synchronous active-high reset.
module ysyx_25060170_reg #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= RESET_VAL;
    else if (wen) q <= d;
  end

endmodule

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch: owns the PC, one outstanding imem read, registered slot to decode.
module ysyx_25060170_ifu #(
  parameter logic [31:0] RESET_PC = ysyx_25060170_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = ysyx_25060170_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rerr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        fetch_err_o
);
  import ysyx_25060170_pkg::*;

  ifu_state_t  state;
  logic        drop;
  logic        req_vld;
  logic        inst_vld;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        pc_wen;
  logic [31:0] tgt;
  logic        resp_take;
  logic        handshake;
  ifu_slot_t   slot_d;

  assign tgt       = align4(redirect_pc_i);
  assign resp_take = (state == WAIT) && imem_rvalid_i && !drop && !redirect_i;
  assign handshake = (state == HOLD) && inst_ready_i;

  // Redirect wins over the sequential increment in every state
  always_comb begin
    pc_wen = 1'b0;
    pc_nxt = pc + PC_INCR;
    if (redirect_i) begin
      pc_wen = 1'b1;
      pc_nxt = tgt;
    end else if (handshake) begin
      pc_wen = 1'b1;
    end
  end

  assign slot_d.pc   = pc;
  assign slot_d.inst = imem_rerr_i ? NOP_INST : imem_rdata_i;
  assign slot_d.err  = imem_rerr_i;

  ysyx_25060170_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .wen(pc_wen), .d(pc_nxt), .q(pc)
  );

  ysyx_25060170_reg #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_o (
    .clk(clk), .rst(rst), .wen(resp_take), .d(slot_d.pc), .q(pc_o)
  );

  ysyx_25060170_reg #(.WIDTH(32), .RESET_VAL(NOP_INST)) u_inst_o (
    .clk(clk), .rst(rst), .wen(resp_take), .d(slot_d.inst), .q(inst_o)
  );

  ysyx_25060170_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_err_o (
    .clk(clk), .rst(rst), .wen(resp_take), .d(slot_d.err), .q(fetch_err_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      drop     <= 1'b0;
      req_vld  <= 1'b0;
      inst_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en_i) begin
            state   <= REQ;
            req_vld <= 1'b1;
          end
        end
        REQ: begin
          if (imem_req_ready_i) begin
            state   <= WAIT;
            req_vld <= 1'b0;
            // request left at the old PC; its response is wrong-path
            drop    <= redirect_i;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (drop || redirect_i) begin
              state   <= REQ;
              drop    <= 1'b0;
              req_vld <= 1'b1;
            end else begin
              state    <= HOLD;
              inst_vld <= 1'b1;
            end
          end else if (redirect_i) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (inst_ready_i) begin
            inst_vld <= 1'b0;
            if (fetch_en_i) begin
              state   <= REQ;
              req_vld <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (redirect_i) begin
            state    <= REQ;
            inst_vld <= 1'b0;
            req_vld  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_vld  <= 1'b0;
          inst_vld <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid_o = req_vld;
  assign inst_valid_o     = inst_vld;
  assign imem_addr_o      = align4(pc);

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed cycle-level bench for the fetch unit with hand-computed expectations.
module tb_ysyx_25060170_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_rerr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        fetch_err_o;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  ysyx_25060170_ifu dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_addr_o(imem_addr_o), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .imem_rerr_i(imem_rerr_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .pc_o(pc_o), .inst_o(inst_o), .fetch_err_o(fetch_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // in REQ: check the request, get it accepted, land in WAIT
  task automatic issue(input string tag, input logic [31:0] addr);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid_o}, 32'd1);
    chk({tag, ".addr"}, imem_addr_o, addr);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    chk({tag, ".wait_req_valid"}, {31'd0, imem_req_valid_o}, 32'd0);
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    imem_rerr_i   = err;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rerr_i   = 1'b0;
    imem_rdata_i  = 32'h0;
  endtask

  task automatic chk_slot(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic err);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid_o}, 32'd1);
    chk({tag, ".pc_o"}, pc_o, pc);
    chk({tag, ".inst_o"}, inst_o, inst);
    chk({tag, ".err"}, {31'd0, fetch_err_o}, {31'd0, err});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid_o}, 32'd0);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid_o}, 32'd0);
    chk({tag, ".inst_o"}, inst_o, 32'h0000_0013);
    chk({tag, ".pc_o"}, pc_o, 32'h8000_0000);
    chk({tag, ".err"}, {31'd0, fetch_err_o}, 32'd0);
    chk({tag, ".addr"}, imem_addr_o, 32'h8000_0000);
  endtask

  logic [31:0] seq_data [3];

  initial begin
    seq_data[0] = 32'h0010_0093;
    seq_data[1] = 32'h0020_0113;
    seq_data[2] = 32'h0030_0193;

    rst = 1'b1; fetch_en_i = 1'b0; imem_req_ready_i = 1'b0; imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0; imem_rerr_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; inst_ready_i = 1'b0;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;

    // sequential fetch, one instruction per REQ/WAIT/HOLD
    fetch_en_i = 1'b1; inst_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      issue("seq", 32'h8000_0000 + 32'(4 * i));
      respond(seq_data[i], 1'b0);
      chk_slot("seq", 32'h8000_0000 + 32'(4 * i), seq_data[i], 1'b0);
      tick();
      chk("seq.drop_valid", {31'd0, inst_valid_o}, 32'd0);
    end

    // decode stalls for 5 cycles
    inst_ready_i = 1'b0;
    issue("stall", 32'h8000_000C);
    respond(32'h0040_0213, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk_slot("stall", 32'h8000_000C, 32'h0040_0213, 1'b0);
      chk("stall.no_req", {31'd0, imem_req_valid_o}, 32'd0);
      tick();
    end
    chk_slot("stall_end", 32'h8000_000C, 32'h0040_0213, 1'b0);
    inst_ready_i = 1'b1;
    tick();

    // access fault
    issue("fault", 32'h8000_0010);
    respond(32'hDEAD_BEEF, 1'b1);
    chk_slot("fault", 32'h8000_0010, 32'h0000_0013, 1'b1);
    tick();
    issue("after_fault", 32'h8000_0014);
    respond(32'h0050_0293, 1'b0);
    chk_slot("after_fault", 32'h8000_0014, 32'h0050_0293, 1'b0);
    tick();

    // redirect while waiting: response must be dropped
    issue("wait_redir", 32'h8000_0018);
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
    tick();
    redirect_i = 1'b0;
    chk("wait_redir.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    respond(32'hBAD0_0BAD, 1'b0);
    chk("wait_redir.dropped", {31'd0, inst_valid_o}, 32'd0);
    issue("wait_redir.new", 32'h8000_0100);
    respond(32'h0060_0313, 1'b0);
    chk_slot("wait_redir.slot", 32'h8000_0100, 32'h0060_0313, 1'b0);

    // redirect in HOLD together with the handshake; low bits ignored
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0203;
    tick();
    redirect_i = 1'b0;
    chk("hold_redir.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("hold_redir.req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("hold_redir.addr", imem_addr_o, 32'h8000_0200);

    // redirect in REQ without accept, then wrap of pc + 4
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    issue("wrap", 32'hFFFF_FFFC);
    respond(32'h0070_0393, 1'b0);
    chk_slot("wrap", 32'hFFFF_FFFC, 32'h0070_0393, 1'b0);
    tick();
    chk("wrap.addr", imem_addr_o, 32'h0000_0000);

    // reset while waiting, then stale responses in IDLE and REQ
    issue("rst_wait", 32'h0000_0000);
    rst = 1'b1;
    tick();
    chk_reset("rst_wait");
    rst = 1'b0; fetch_en_i = 1'b0;
    respond(32'h5A5A_5A5A, 1'b0);
    chk("stale_idle.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("stale_idle.req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    fetch_en_i = 1'b1;
    tick();
    respond(32'hA5A5_A5A5, 1'b0);
    chk("stale_req.inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("stale_req.req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("stale_req.addr", imem_addr_o, 32'h8000_0000);
    chk("stale_req.inst_o", inst_o, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
